// File: rtl/game_pkg.sv
// Shared types and constants for the four-lane rhythm game: game states,
// lane geometry and the spawn LFSR step.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } game_state_t;

  localparam int NUM_LANES   = 4;
  localparam int SCREEN_ROWS = 480;
  localparam int ROW_W       = 10;

  localparam int LANE_GREEN  = 0;
  localparam int LANE_YELLOW = 1;
  localparam int LANE_BLUE   = 2;
  localparam int LANE_ORANGE = 3;

  // Fibonacci LFSR, taps 8,6,5,4 (bits 7,5,4,3), shifting toward the MSB.
  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return {2'b0, v[0]} + {2'b0, v[1]} + {2'b0, v[2]} + {2'b0, v[3]};
  endfunction

endpackage

// File: rtl/bcd_score_counter.sv
// Five-digit BCD score register: adds 0..4 per cycle, saturates at 99999,
// synchronous clear has priority over the add.
module bcd_score_counter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic [2:0]  add,
  output logic [19:0] score
);

  logic [19:0] score_next;
  logic [4:0]  digit_sum;
  logic [2:0]  carry;

  // NOTE: every variable written here gets a value before any branch, so no latch is inferred.
  always_comb begin
    score_next = score;
    digit_sum  = '0;
    carry      = add;
    for (int d = 0; d < 5; d++) begin
      digit_sum = {1'b0, score[4*d +: 4]} + {2'b0, carry};
      if (digit_sum > 5'd9) begin
        score_next[4*d +: 4] = 4'(digit_sum - 5'd10);
        carry                = 3'd1;
      end else begin
        score_next[4*d +: 4] = digit_sum[3:0];
        carry                = 3'd0;
      end
    end
    if (carry != 3'd0) score_next = 20'h99999;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   score <= '0;
    else if (clr) score <= '0;
    else          score <= score_next;
  end

endmodule

// File: rtl/note_scheduler.sv
// Note scheduler for a four-lane falling-note game: spawns notes from an LFSR,
// moves them once per frame and scores button presses against a hit window.
module note_scheduler
  import game_pkg::*;
#(
  parameter int         FALL_STEP    = 4,
  parameter int         SPAWN_PERIOD = 30,
  parameter int         HIT_TOP      = 400,
  parameter int         HIT_BOT      = 440,
  parameter int         MAX_MISS     = 3,
  parameter logic [7:0] LFSR_SEED    = 8'hA5
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                frame_tick,
  input  logic [NUM_LANES-1:0]                btn,
  output logic [NUM_LANES-1:0]                note_valid,
  output logic [NUM_LANES-1:0][ROW_W-1:0]     note_row,
  output logic [19:0]                         score_bcd,
  output logic [1:0]                          miss_cnt,
  output game_state_t                         state
);

  localparam int CNT_W = $clog2(SPAWN_PERIOD + 1);
  localparam logic [CNT_W-1:0] SPAWN_LAST = CNT_W'(SPAWN_PERIOD - 1);
  localparam logic [ROW_W:0]   STEP_R     = (ROW_W + 1)'(FALL_STEP);
  localparam logic [ROW_W:0]   BOTTOM_R   = (ROW_W + 1)'(SCREEN_ROWS);
  localparam logic [ROW_W-1:0] HIT_TOP_R  = ROW_W'(HIT_TOP);
  localparam logic [ROW_W-1:0] HIT_BOT_R  = ROW_W'(HIT_BOT);
  localparam logic [1:0]       MISS_LIM   = 2'(MAX_MISS);

  game_state_t                    state_next;
  logic [NUM_LANES-1:0]           btn_q;
  logic [NUM_LANES-1:0]           rise;
  logic [CNT_W-1:0]               spawn_cnt, spawn_cnt_next;
  logic [7:0]                     lfsr_q, lfsr_next;
  logic [NUM_LANES-1:0]           valid_next, hit_mask;
  logic [NUM_LANES-1:0][ROW_W-1:0] row_next;
  logic [1:0]                     miss_next;
  logic [3:0]                     miss_sum;
  logic [4:0]                     miss_total;
  logic [ROW_W:0]                 moved;
  logic                           score_clr;

  assign rise = btn & ~btn_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (|rise) state_next = PLAY;
      PLAY:    if (miss_cnt == MISS_LIM) state_next = OVER;
      OVER:    if (|rise) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    valid_next     = note_valid;
    row_next       = note_row;
    miss_next      = miss_cnt;
    spawn_cnt_next = spawn_cnt;
    lfsr_next      = lfsr_q;
    hit_mask       = '0;
    miss_sum       = '0;
    miss_total     = '0;
    moved          = '0;
    score_clr      = 1'b0;

    if (state == IDLE && state_next == PLAY) begin
      valid_next     = '0;
      miss_next      = '0;
      spawn_cnt_next = '0;
      score_clr      = 1'b1;
    end else if (state == PLAY && state_next == PLAY) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        // Presses see the pre-tick row; a hit note is removed before it can move.
        if (rise[l]) begin
          if (note_valid[l] && note_row[l] >= HIT_TOP_R && note_row[l] <= HIT_BOT_R) begin
            hit_mask[l]   = 1'b1;
            valid_next[l] = 1'b0;
          end else begin
            miss_sum = miss_sum + 4'd1;
          end
        end
        if (frame_tick && note_valid[l] && !hit_mask[l]) begin
          moved = {1'b0, note_row[l]} + STEP_R;
          if (moved >= BOTTOM_R) begin
            valid_next[l] = 1'b0;
            row_next[l]   = '0;
            miss_sum      = miss_sum + 4'd1;
          end else begin
            row_next[l] = moved[ROW_W-1:0];
          end
        end
      end

      if (frame_tick) begin
        if (spawn_cnt == SPAWN_LAST) begin
          spawn_cnt_next = '0;
          lfsr_next      = lfsr_step(lfsr_q);
          if (!valid_next[lfsr_next[1:0]]) begin
            valid_next[lfsr_next[1:0]] = 1'b1;
            row_next[lfsr_next[1:0]]   = '0;
          end
        end else begin
          spawn_cnt_next = spawn_cnt + 1'b1;
        end
      end

      miss_total = {3'b0, miss_cnt} + {1'b0, miss_sum};
      miss_next  = (miss_total >= {3'b0, MISS_LIM}) ? MISS_LIM : miss_total[1:0];
    end else if (state == PLAY) begin
      valid_next = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_q      <= '0;
      note_valid <= '0;
      note_row   <= '0;
      miss_cnt   <= '0;
      spawn_cnt  <= '0;
      lfsr_q     <= LFSR_SEED;
    end else begin
      btn_q      <= btn;
      note_valid <= valid_next;
      note_row   <= row_next;
      miss_cnt   <= miss_next;
      spawn_cnt  <= spawn_cnt_next;
      lfsr_q     <= lfsr_next;
    end
  end

  bcd_score_counter u_score (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (score_clr),
    .add   (popcount4(hit_mask)),
    .score (score_bcd)
  );

endmodule

// File: tb/tb_note_scheduler.sv
// Directed bench for note_scheduler: a start-up vector table followed by
// hand-computed multi-cycle sequences for spawning, hits, misses and reset.
module tb_note_scheduler;
  import game_pkg::*;

  logic                        clk = 1'b0;
  logic                        rst_n = 1'b0;
  logic                        frame_tick = 1'b0;
  logic [NUM_LANES-1:0]        btn = '0;
  logic [NUM_LANES-1:0]        note_valid;
  logic [NUM_LANES-1:0][9:0]   note_row;
  logic [19:0]                 score_bcd;
  logic [1:0]                  miss_cnt;
  game_state_t                 state;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0]  btn;
    logic        tick;
    game_state_t st;
    logic [19:0] score;
    logic [1:0]  miss;
    logic [3:0]  valid;
  } vec_t;

  vec_t vecs[4];

  always #5 clk = ~clk;

  note_scheduler dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .btn        (btn),
    .note_valid (note_valid),
    .note_row   (note_row),
    .score_bcd  (score_bcd),
    .miss_cnt   (miss_cnt),
    .state      (state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a falling edge; drives inputs for one cycle and returns at the next falling edge.
  task automatic step(input logic [3:0] b, input logic t);
    btn        = b;
    frame_tick = t;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(4'b0000, 1'b1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " state"}, 32'(state), 32'(IDLE));
    check({tag, " valid"}, 32'(note_valid), 32'h0);
    for (int l = 0; l < NUM_LANES; l++)
      check($sformatf("%s row%0d", tag, l), 32'(note_row[l]), 32'h0);
    check({tag, " score"}, 32'(score_bcd), 32'h0);
    check({tag, " miss"}, 32'(miss_cnt), 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{4'b0000, 1'b1, IDLE, 20'h00000, 2'd0, 4'b0000};
    vecs[1] = '{4'b0001, 1'b0, PLAY, 20'h00000, 2'd0, 4'b0000};
    vecs[2] = '{4'b0001, 1'b0, PLAY, 20'h00000, 2'd0, 4'b0000};
    vecs[3] = '{4'b0000, 1'b0, PLAY, 20'h00000, 2'd0, 4'b0000};

    repeat (2) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      step(vecs[i].btn, vecs[i].tick);
      check($sformatf("vec%0d state", i), 32'(state), 32'(vecs[i].st));
      check($sformatf("vec%0d score", i), 32'(score_bcd), 32'(vecs[i].score));
      check($sformatf("vec%0d miss", i), 32'(miss_cnt), 32'(vecs[i].miss));
      check($sformatf("vec%0d valid", i), 32'(note_valid), 32'(vecs[i].valid));
    end

    // Spawns: tick 30 -> LFSR 4A lane 2; tick 60 -> 95 lane 1.
    ticks(29);
    check("no early spawn", 32'(note_valid), 32'h0);
    ticks(1);
    check("spawn1 valid", 32'(note_valid), 32'(4'b0100));
    check("spawn1 row", 32'(note_row[LANE_BLUE]), 32'd0);
    ticks(30);
    check("spawn2 valid", 32'(note_valid), 32'(4'b0110));
    check("spawn2 row blue", 32'(note_row[LANE_BLUE]), 32'd120);
    check("spawn2 row yellow", 32'(note_row[LANE_YELLOW]), 32'd0);

    // Tick 90 -> 2A lane 2 occupied, skipped; tick 120 -> 54 lane 0.
    ticks(69);
    check("t129 valid", 32'(note_valid), 32'(4'b0111));
    check("t129 row blue", 32'(note_row[LANE_BLUE]), 32'd396);
    check("t129 row green", 32'(note_row[LANE_GREEN]), 32'd36);
    step(4'b0100, 1'b0);
    check("early press miss", 32'(miss_cnt), 32'd1);
    check("early press kept", 32'(note_valid), 32'(4'b0111));
    check("early press row", 32'(note_row[LANE_BLUE]), 32'd396);
    check("early press score", 32'(score_bcd), 32'h0);
    step(4'b0000, 1'b1);
    check("t130 row blue", 32'(note_row[LANE_BLUE]), 32'd400);
    step(4'b0100, 1'b0);
    check("hit400 score", 32'(score_bcd), 32'h00001);
    check("hit400 valid", 32'(note_valid), 32'(4'b0011));
    check("hit400 miss", 32'(miss_cnt), 32'd1);
    step(4'b0000, 1'b0);

    // Tick 150 -> A9 lane 1 occupied; tick 180 -> lane 1 falls out, 53 spawns lane 3.
    ticks(49);
    check("t179 row yellow", 32'(note_row[LANE_YELLOW]), 32'd476);
    check("t179 valid", 32'(note_valid), 32'(4'b0011));
    ticks(1);
    check("fallout miss", 32'(miss_cnt), 32'd2);
    check("fallout valid", 32'(note_valid), 32'(4'b1001));
    check("fallout row green", 32'(note_row[LANE_GREEN]), 32'd240);
    check("spawn lane3 row", 32'(note_row[LANE_ORANGE]), 32'd0);
    step(4'b0110, 1'b0);
    check("miss sat", 32'(miss_cnt), 32'd3);
    check("miss sat state", 32'(state), 32'(PLAY));
    step(4'b0000, 1'b0);
    check("over state", 32'(state), 32'(OVER));
    check("over valid", 32'(note_valid), 32'h0);
    check("over score hold", 32'(score_bcd), 32'h00001);
    step(4'b0000, 1'b1);
    check("over tick ignored", 32'(note_valid), 32'h0);
    check("over tick state", 32'(state), 32'(OVER));
    step(4'b1000, 1'b0);
    check("to idle state", 32'(state), 32'(IDLE));
    check("idle score hold", 32'(score_bcd), 32'h00001);
    check("idle miss hold", 32'(miss_cnt), 32'd3);
    step(4'b0000, 1'b0);
    step(4'b0010, 1'b0);
    check("replay state", 32'(state), 32'(PLAY));
    check("replay score", 32'(score_bcd), 32'h0);
    check("replay miss", 32'(miss_cnt), 32'd0);
    step(4'b0000, 1'b0);

    // Four simultaneous hits coincident with a tick.
    force dut.note_valid = 4'b1111;
    force dut.note_row   = {4{10'd420}};
    #1;
    release dut.note_valid;
    release dut.note_row;
    step(4'b1111, 1'b1);
    check("hit4 score", 32'(score_bcd), 32'h00004);
    check("hit4 miss", 32'(miss_cnt), 32'd0);
    check("hit4 valid", 32'(note_valid), 32'h0);
    for (int l = 0; l < NUM_LANES; l++)
      check($sformatf("hit4 row%0d", l), 32'(note_row[l]), 32'd420);
    step(4'b0000, 1'b0);

    force dut.u_score.score = 20'h99998;
    force dut.note_valid    = 4'b1111;
    force dut.note_row      = {4{10'd420}};
    #1;
    release dut.u_score.score;
    release dut.note_valid;
    release dut.note_row;
    step(4'b1111, 1'b0);
    check("score sat", 32'(score_bcd), 32'h99999);
    check("score sat miss", 32'(miss_cnt), 32'd0);
    step(4'b0000, 1'b0);

    // Asynchronous reset in the middle of a game.
    force dut.u_score.score = 20'h00012;
    force dut.note_valid    = 4'b0101;
    #1;
    release dut.u_score.score;
    release dut.note_valid;
    step(4'b0000, 1'b0);
    check("pre-reset score", 32'(score_bcd), 32'h00012);
    check("pre-reset valid", 32'(note_valid), 32'(4'b0101));
    #2 rst_n = 1'b0;
    #1;
    check_reset_values("midreset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_values("postreset");

    // Hit coincident with the spawn tick: LFSR restarts at the seed, so lane 2 respawns.
    step(4'b0001, 1'b0);
    check("game3 state", 32'(state), 32'(PLAY));
    step(4'b0000, 1'b0);
    ticks(29);
    force dut.note_valid = 4'b0100;
    force dut.note_row   = {10'd0, 10'd420, 10'd0, 10'd0};
    #1;
    release dut.note_valid;
    release dut.note_row;
    step(4'b0100, 1'b1);
    check("hit+spawn score", 32'(score_bcd), 32'h00001);
    check("hit+spawn valid", 32'(note_valid), 32'(4'b0100));
    check("hit+spawn row", 32'(note_row[LANE_BLUE]), 32'd0);
    check("hit+spawn miss", 32'(miss_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
